vga_line_fetch: RTL and testbench

- Pixel source directly upstream of the VGA timing controller.
- Prefetches each active line of RGB565 pixels from a burst memory read port into a ping-pong pair of line buffers.
- Serves the controller's data_req with pix_data exactly one vga_clk later.
- Re-aligns to every frame on the falling edge of vga_vs and flags underruns.

---
 rtl/vga_line_fetch.sv | 120 ++++++++++++
 tb/tb_vga_line_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Line prefetcher for the VGA timing controller: bursts each active line into
// one half of a ping-pong buffer and serves pixels one cycle after data_req.
module vga_line_fetch #(
  parameter int                H_PIX          = 800,
  parameter int                V_PIX          = 600,
  parameter int                ADDR_W         = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [15:0]       UNDERRUN_COLOR = 16'hF800
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              vga_vs,
  input  logic              data_req,
  output logic [15:0]       pix_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_data_vld,
  input  logic [15:0]       rd_data,
  output logic              underrun
);
  localparam int PW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int OW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_PIX + 1);
  localparam logic [PW-1:0] LAST = PW'(H_PIX - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;
  state_t state, state_nxt;

  logic          vs_d1, frame_start;
  logic [1:0]    bank_valid;
  logic          rd_bank, wr_bank;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] line_idx;
  logic [OW-1:0] owed, owed_abort;
  logic          wr_en, fill_done, served_last;
  logic [15:0]   mem [2][H_PIX];

  assign frame_start = vs_d1 & ~vga_vs;
  assign rd_req      = (state == REQ);
  assign wr_en       = (state == RECV) && rd_data_vld && !frame_start && !sys_rst;
  assign fill_done   = wr_en && (wr_ptr == LAST);
  assign served_last = data_req && (rd_ptr == LAST);
  // Words the memory still owes if the burst is abandoned this cycle; a strobe
  // arriving alongside frame_start is already paid and dropped.
  assign owed_abort  = OW'(H_PIX) - OW'(wr_ptr) - OW'(rd_data_vld);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!frame_start && !bank_valid[wr_bank] && line_idx < LW'(V_PIX))
               state_nxt = REQ;
      REQ:   if (rd_ack) state_nxt = frame_start ? DRAIN : RECV;
      RECV:  if (frame_start)    state_nxt = (owed_abort == '0) ? IDLE : DRAIN;
             else if (fill_done) state_nxt = IDLE;
      DRAIN: if (rd_data_vld && owed == OW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (wr_en) mem[wr_bank][wr_ptr] <= rd_data;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vs_d1      <= 1'b0;
      pix_data   <= '0;
      underrun   <= 1'b0;
      bank_valid <= '0;
      rd_bank    <= 1'b0;
      wr_bank    <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      line_idx   <= '0;
      rd_addr    <= BASE_ADDR;
      owed       <= '0;
    end else begin
      vs_d1    <= vga_vs;
      pix_data <= !data_req              ? 16'h0 :
                  bank_valid[rd_bank]    ? mem[rd_bank][rd_ptr] : UNDERRUN_COLOR;
      if (frame_start) begin
        underrun   <= 1'b0;
        bank_valid <= '0;
        rd_bank    <= 1'b0;
        wr_bank    <= 1'b0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        line_idx   <= '0;
        rd_addr    <= BASE_ADDR;
      end else begin
        // An unready bank still advances the pointer so the line stays aligned.
        if (data_req) begin
          rd_ptr <= served_last ? '0 : rd_ptr + 1'b1;
          if (!bank_valid[rd_bank]) underrun <= 1'b1;
          else if (served_last) begin
            bank_valid[rd_bank] <= 1'b0;
            rd_bank             <= ~rd_bank;
          end
        end
        if (state == REQ && rd_ack) wr_ptr <= '0;
        if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (fill_done) begin
          bank_valid[wr_bank] <= 1'b1;
          wr_bank             <= ~wr_bank;
          line_idx            <= line_idx + 1'b1;
          rd_addr             <= rd_addr + ADDR_W'(H_PIX);
        end
      end
      if (state == REQ && rd_ack && frame_start) owed <= OW'(H_PIX);
      else if (state == RECV && frame_start)     owed <= owed_abort;
      else if (state == DRAIN && rd_data_vld)    owed <= owed - 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch on a scaled 8x4 frame with a burst memory model.
module tb_vga_line_fetch;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 12;
  localparam logic [AW-1:0] BASE = 12'h010;

  logic          vga_clk = 0, sys_rst = 1, vga_vs = 1, data_req = 0;
  logic          rd_ack = 0, rd_data_vld = 0, rd_req, underrun;
  logic [15:0]   rd_data = 0, pix_data;
  logic [AW-1:0] rd_addr;

  int n_chk = 0, n_pass = 0;
  int mem_en = 0, ack_lat = 3, duty = 100, stray = 0, m_wait = 0, m_cnt = 0;
  logic          m_busy = 0;
  logic [AW-1:0] m_addr = 0;
  logic [15:0]   dkey = 0, m_key = 0;
  logic [AW-1:0] bursts[$];

  vga_line_fetch #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW), .BASE_ADDR(BASE),
                   .UNDERRUN_COLOR(16'hF800)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .vga_vs(vga_vs), .data_req(data_req),
    .pix_data(pix_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .underrun(underrun));

  always #5 vga_clk = ~vga_clk;

  // Burst memory: ack after ack_lat cycles of rd_req, then H words of addr+i (xor key).
  always @(posedge vga_clk) begin
    #1;
    rd_ack = 0; rd_data_vld = 0;
    if (sys_rst && stray == 0) begin
      m_busy = 0; m_wait = 0;
    end else if (m_busy) begin
      if ($urandom_range(99) < duty) begin
        rd_data_vld = 1;
        rd_data = (16'(m_addr) + 16'(m_cnt)) ^ m_key;
        m_cnt++;
        if (m_cnt == H) m_busy = 0;
      end
    end else if (rd_req && mem_en != 0) begin
      if (m_wait >= ack_lat - 1) begin
        rd_ack = 1; m_busy = 1; m_cnt = 0; m_wait = 0;
        m_addr = rd_addr; m_key = dkey;
        bursts.push_back(rd_addr);
      end else m_wait++;
    end else m_wait = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge vga_clk); #2;
  endtask

  task automatic pulse_vs;
    vga_vs = 0; tick; vga_vs = 1;
  endtask

  task automatic play(input int lines, input int gap);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < H; x++) begin
        data_req = 1; tick;
        chk("pix", pix_data, 32'(BASE) + y*H + x);
      end
      data_req = 0; tick;
      chk("pix_idle", pix_data, 0);
      repeat (gap - 1) tick;
    end
  endtask

  initial begin
    int ok, x, y;
    // reset values
    repeat (2) tick;
    chk("rst_pix", pix_data, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, BASE);
    chk("rst_urun", underrun, 0);
    sys_rst = 0; tick;
    chk("req_after_rst", rd_req, 1);

    // full frame, 3-cycle ack, strobe every cycle
    pulse_vs;
    bursts.delete(); mem_en = 1;
    repeat (30) tick;
    chk("prefetch_n", bursts.size(), 2);
    chk("prefetch_b0", bursts[0], BASE);
    chk("prefetch_b1", bursts[1], BASE + H);
    play(V, 16);
    chk("frame_urun", underrun, 0);
    for (int i = 0; i < 10; i++) begin tick; chk("eof_req", rd_req, 0); end
    chk("frame_nburst", bursts.size(), V);
    for (int k = 0; k < V; k++) chk("frame_addr", bursts[k], 32'(BASE) + k*H);

    // stalled memory: underrun color and sticky flag, cleared by next frame
    mem_en = 0;
    pulse_vs;
    for (int i = 0; i < H; i++) begin
      data_req = 1; tick;
      chk("urun_pix", pix_data, 16'hF800);
    end
    data_req = 0; tick;
    chk("urun_flag", underrun, 1);
    pulse_vs;
    chk("urun_clr", underrun, 0);
    chk("urun_req_held", rd_req, 1);

    // frame_start mid-burst: remaining words drained, aborted data never shown
    bursts.delete(); dkey = 16'h5000; mem_en = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (m_busy && m_cnt == 3) begin ok = 1; break; end
    end
    chk("abort_sync", ok, 1);
    dkey = 0;
    pulse_vs;
    repeat (50) tick;
    chk("abort_nburst", bursts.size(), 3);
    chk("abort_b1", bursts[1], BASE);
    chk("abort_b2", bursts[2], BASE + H);
    play(V, 16);
    chk("abort_urun", underrun, 0);

    // gapped strobes at 30% duty
    duty = 30;
    pulse_vs;
    repeat (150) tick;
    play(V, 80);
    chk("gap_urun", underrun, 0);
    duty = 100;

    // reset mid-RECV and mid-line with stray strobes continuing
    pulse_vs;
    repeat (40) tick;
    x = 0; y = 0; ok = 0;
    for (int i = 0; i < 100; i++) begin
      data_req = 1; tick;
      chk("mid_pix", pix_data, 32'(BASE) + y*H + x);
      x++;
      if (x == H) begin x = 0; y++; end
      if (m_busy && m_cnt == 3) begin ok = 1; break; end
    end
    chk("mid_sync", ok, 1);
    stray = 1; sys_rst = 1; tick;
    chk("mid_rst_pix", pix_data, 0);
    chk("mid_rst_req", rd_req, 0);
    chk("mid_rst_addr", rd_addr, BASE);
    chk("mid_rst_urun", underrun, 0);
    sys_rst = 0; data_req = 0; bursts.delete();
    repeat (60) tick;
    stray = 0;
    chk("post_rst_nburst", bursts.size(), 2);
    chk("post_rst_b0", bursts[0], BASE);
    chk("post_rst_b1", bursts[1], BASE + H);
    play(V, 16);
    chk("post_rst_urun", underrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
